// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared constants for the nRisc ALU stage.
//   WIDTH         datapath width
//   MUL_CYC       multiply iterations (one per operand-B bit)
//   OP_ADD..OP_MUL  3-bit op codes
//   state_t       ALU sequencer states (ST_IDLE, ST_MUL)
package nrisc_pkg;

   localparam int WIDTH   = 8;
   localparam int MUL_CYC = WIDTH;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/nrisc_alu_seq_if.sv
// nrisc_alu_seq_if: handshake/operand bus between the control unit and the ALU stage.
//   start, op, a, b                      : control unit -> ALU
//   result, zero, carry, busy, done      : ALU -> control unit
// Modports: master (control unit / testbench), slave (ALU).
interface nrisc_alu_seq_if;
   import nrisc_pkg::*;

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             busy;
   logic             done;

   modport master (
      output start, op, a, b,
      input  result, zero, carry, busy, done
   );

   modport slave (
      input  start, op, a, b,
      output result, zero, carry, busy, done
   );

endinterface

// File: rtl/nrisc_alu_comb.sv
// nrisc_alu_comb: purely combinational single-cycle ALU operations and flags.
//   i_op      op code (OP_ADD..OP_MUL)
//   i_a, i_b  operands
//   o_result  operation result (0 for OP_MUL; multiply is sequenced elsewhere)
//   o_zero    o_result == 0
//   o_carry   ADD carry-out / SUB borrow; 0 for all other ops
module nrisc_alu_comb
   import nrisc_pkg::*;
(
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_zero,
   output logic             o_carry
);

   logic [WIDTH:0] w_sum;

   assign w_sum = {1'b0, i_a} + {1'b0, i_b};

   always_comb begin
      o_result = '0;
      o_carry  = 1'b0;
      case (i_op)
         OP_ADD: {o_carry, o_result} = w_sum;
         OP_SUB: begin
            o_result = i_a - i_b;
            o_carry  = (i_a < i_b);          // unsigned borrow
         end
         OP_AND: o_result = i_a & i_b;
         OP_OR:  o_result = i_a | i_b;
         OP_SLT: o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         OP_SLL: o_result = i_a << i_b[2:0];
         OP_SRL: o_result = i_a >> i_b[2:0];
         default: begin
            o_result = '0;                   // OP_MUL: handled by the sequencer
            o_carry  = 1'b0;
         end
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule

// File: rtl/nrisc_alu_seq.sv
// nrisc_alu_seq: 8-bit ALU stage with start/busy/done handshake and registered
// result/flags. Single-cycle ops complete on the start edge; MUL is an 8-step
// shift-add sequence.
//   i_clock   rising-edge clock
//   i_reset   synchronous active-high reset
//   io_alu    nrisc_alu_seq_if.slave (start/op/a/b in, result/zero/carry/busy/done out)
// Build option: NRISC_ALU_MUL_EN compiles in the MUL state and shift-add datapath.
// Without it, op 111 completes in one cycle with result=0, zero=1, carry=0.
module nrisc_alu_seq
   import nrisc_pkg::*;
(
   input  logic           i_clock,
   input  logic           i_reset,
   nrisc_alu_seq_if.slave io_alu
);

   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_carry;
   logic             r_done;

   logic [WIDTH-1:0] w_res;
   logic             w_zero;
   logic             w_carry;

   nrisc_alu_comb u_comb (
      .i_op     (io_alu.op),
      .i_a      (io_alu.a),
      .i_b      (io_alu.b),
      .o_result (w_res),
      .o_zero   (w_zero),
      .o_carry  (w_carry)
   );

`ifdef NRISC_ALU_MUL_EN
   state_t             r_state;
   logic [2:0]         r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_busy;
   logic [2*WIDTH-1:0] w_acc_next;

   // Partial product for the current multiplier bit; the final step's sum
   // is used directly so result/carry land on the same edge as done.
   assign w_acc_next = r_acc + (r_b[r_cnt] ? ({{WIDTH{1'b0}}, r_a} << r_cnt)
                                           : {(2*WIDTH){1'b0}});

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_busy   <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_carry  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (io_alu.start) begin
                  if (io_alu.op == OP_MUL) begin
                     r_a     <= io_alu.a;
                     r_b     <= io_alu.b;
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= ST_MUL;
                  end else begin
                     r_result <= w_res;
                     r_zero   <= w_zero;
                     r_carry  <= w_carry;
                     r_done   <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt == 3'(MUL_CYC - 1)) begin
                  r_result <= w_acc_next[WIDTH-1:0];
                  r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
                  r_carry  <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign io_alu.busy = r_busy;
`else
   // Always idle: every start completes on its own edge.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_result <= '0;
         r_zero   <= 1'b1;
         r_carry  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= io_alu.start;
         if (io_alu.start) begin
            r_result <= w_res;
            r_zero   <= w_zero;
            r_carry  <= w_carry;
         end
      end
   end

   assign io_alu.busy = 1'b0;
`endif

   assign io_alu.result = r_result;
   assign io_alu.zero   = r_zero;
   assign io_alu.carry  = r_carry;
   assign io_alu.done   = r_done;

endmodule

// File: tb/tb_nrisc_alu_seq.sv
// tb_nrisc_alu_seq: directed + randomized self-checking bench for nrisc_alu_seq.
// Follows NRISC_ALU_MUL_EN to choose the expected multiply behaviour.
module tb_nrisc_alu_seq;
   import nrisc_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nrisc_alu_seq_if alu_if ();

   nrisc_alu_seq dut (
      .i_clock (clk),
      .i_reset (rst),
      .io_alu  (alu_if.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Expected held outputs (updated on every modelled completion)
   logic [7:0] e_res;
   logic       e_zero;
   logic       e_carry;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic from the op definitions.
   function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic c);
      int ia = int'(a);
      int ib = int'(b);
      int sa = (ia > 127) ? ia - 256 : ia;
      int sb = (ib > 127) ? ib - 256 : ib;
      int s;
      r = 8'h00; c = 1'b0;
      case (op)
         3'd0: begin s = ia + ib;            r = s[7:0]; c = (s > 255); end
         3'd1: begin s = ia - ib + 256;      r = s[7:0]; c = (ia < ib); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = (sa < sb) ? 8'd1 : 8'd0;
         3'd5: begin s = ia * (2 ** (ib % 8)); r = s[7:0]; end
         3'd6: begin s = ia / (2 ** (ib % 8)); r = s[7:0]; end
         default: begin
`ifdef NRISC_ALU_MUL_EN
            s = ia * ib; r = s[7:0]; c = (s > 255);
`else
            r = 8'h00; c = 1'b0;
`endif
         end
      endcase
   endfunction

   task automatic check_outs(input string tag, input logic done_e, input logic busy_e);
      chk({tag, ".done"},   32'(alu_if.done),   32'(done_e));
      chk({tag, ".busy"},   32'(alu_if.busy),   32'(busy_e));
      chk({tag, ".result"}, 32'(alu_if.result), 32'(e_res));
      chk({tag, ".zero"},   32'(alu_if.zero),   32'(e_zero));
      chk({tag, ".carry"},  32'(alu_if.carry),  32'(e_carry));
   endtask

   // Present a single-cycle op for one edge; start is left high so the caller
   // can chain another op back-to-back or go idle.
   task automatic issue(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      alu_if.start = 1'b1; alu_if.op = op; alu_if.a = a; alu_if.b = b;
      model(op, a, b, e_res, e_carry);
      e_zero = (e_res == 8'h00);
      @(posedge clk); #1;
      check_outs(tag, 1'b1, 1'b0);
   endtask

   task automatic idle(input string tag);
      @(negedge clk);
      alu_if.start = 1'b0;
      alu_if.a = 8'($urandom); alu_if.b = 8'($urandom);
      @(posedge clk); #1;
      check_outs(tag, 1'b0, 1'b0);
   endtask

`ifdef NRISC_ALU_MUL_EN
   // Launch MUL; optionally pulse start+ADD on cycle inj, or reset on cycle rst_at.
   task automatic mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input int inj, input int rst_at);
      logic [7:0] r; logic c;
      @(negedge clk);
      alu_if.start = 1'b1; alu_if.op = OP_MUL; alu_if.a = a; alu_if.b = b;
      @(posedge clk); #1;
      chk({tag, ".busy1"}, 32'(alu_if.busy), 32'd1);
      chk({tag, ".done1"}, 32'(alu_if.done), 32'd0);
      for (int cyc = 2; cyc <= 9; cyc++) begin
         @(negedge clk);
         alu_if.start = (cyc == inj);
         alu_if.op = OP_ADD;
         alu_if.a = 8'($urandom); alu_if.b = 8'($urandom);
         rst = (cyc == rst_at);
         @(posedge clk); #1;
         if (rst_at != 0 && cyc >= rst_at) begin
            e_res = 8'h00; e_zero = 1'b1; e_carry = 1'b0;
            check_outs({tag, ".aborted"}, 1'b0, 1'b0);
         end else if (cyc < 9) begin
            chk({tag, ".busy"}, 32'(alu_if.busy), 32'd1);
            chk({tag, ".done"}, 32'(alu_if.done), 32'd0);
         end else begin
            model(OP_MUL, a, b, r, c);
            e_res = r; e_carry = c; e_zero = (r == 8'h00);
            check_outs({tag, ".fin"}, 1'b1, 1'b0);
         end
      end
      @(negedge clk); rst = 1'b0; alu_if.start = 1'b0;
   endtask
`endif

   initial begin
      logic [2:0] rop;
      alu_if.start = 1'b0; alu_if.op = 3'd0; alu_if.a = 8'h00; alu_if.b = 8'h00;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      e_res = 8'h00; e_zero = 1'b1; e_carry = 1'b0;
      check_outs("reset", 1'b0, 1'b0);
      @(negedge clk); rst = 1'b0;

      // Directed vectors
      issue("add_f0_11", OP_ADD, 8'hF0, 8'h11);
      chk("add_f0_11.res_const", 32'(alu_if.result), 32'h01);
      idle("add_pulse");
      issue("sub_eq", OP_SUB, 8'h11, 8'h11);
      issue("sub_borrow", OP_SUB, 8'h0D, 8'h11);   // back-to-back
      chk("sub_borrow.res_const", 32'(alu_if.result), 32'hFC);
      issue("slt_neg", OP_SLT, 8'hFF, 8'h01);
      issue("sll_3", OP_SLL, 8'h11, 8'h03);
      chk("sll_3.res_const", 32'(alu_if.result), 32'h88);
      issue("srl_7", OP_SRL, 8'h80, 8'hFF);
      idle("hold");
      idle("hold2");

`ifdef NRISC_ALU_MUL_EN
      mul("mul_dd", 8'h11, 8'h0D, 0, 0);
      chk("mul_dd.res_const", 32'(alu_if.result), 32'hDD);
      mul("mul_ovf", 8'h20, 8'h10, 0, 0);
      mul("mul_inj", 8'h0F, 8'h0F, 4, 0);
      mul("mul_rst", 8'hA5, 8'h3C, 0, 5);
      idle("post_rst");
      mul("mul_ff", 8'hFF, 8'hFF, 0, 0);
`else
      issue("mul_off", OP_MUL, 8'h11, 8'h0D);
      chk("mul_off.res_const", 32'(alu_if.result), 32'h00);
      idle("mul_off_idle");
`endif

      // Randomized sequence against the reference model
      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(0, 7));
`ifdef NRISC_ALU_MUL_EN
         if (rop == OP_MUL) begin
            mul("rnd_mul", 8'($urandom), 8'($urandom), 0, 0);
            continue;
         end
`endif
         issue("rnd", rop, 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 2) == 0) idle("rnd_idle");
      end
      idle("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
